// File: rtl/vcp_pkg.sv
// rtl/vcp_pkg.sv - shared opcodes, control-word layout and FSM state type for vector_control_pipe
//
// Purpose: one place for the opcode encodings and for the layout of the
// control word that vcp_opcode_decoder produces and vector_control_pipe
// carries through EX/MEM/WB.
// Control word bits: [10] illegal (only with VCP_ILLEGAL_TRAP_EN), [9] vector_wre,
// [8] load, [7] wre, [6] wme, [5:4] wb_sel, [3:0] aluOp; bits above 10 are zero.
package vcp_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDV = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_LDR  = 4'b1001;
    localparam logic [3:0] OP_STR  = 4'b1010;

    localparam logic [1:0] WB_SEL_ALU = 2'b01;
    localparam logic [3:0] ALU_ADD    = 4'b0001;

    // Bit positions the sequencer inspects directly in the padded word.
    localparam int BIT_VECTOR_WRE = 9;
    localparam int BIT_ILLEGAL    = 10;
    localparam int CTRL_USED_W    = 11;

    // Packed so that bit 0 is alu_op[0] and bit 10 is illegal.
    typedef struct packed {
        logic       illegal;
        logic       vector_wre;
        logic       load;
        logic       wre;
        logic       wme;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
    } ctrl_word_t;

    typedef enum logic {
        ST_IDLE,
        ST_VEC_ISSUE
    } vcp_state_t;

endpackage

// File: rtl/vcp_opcode_decoder.sv
// rtl/vcp_opcode_decoder.sv - combinational opcode to control-word decoder
//
// Ports:
//   opcode    in  OPCODE_W  instruction opcode
//   ctrl_word out CTRL_W    zero-padded control word
// Macro VCP_ILLEGAL_TRAP_EN: when defined, unknown opcodes set the illegal
// bit (10); otherwise they decode as a nop.
module vcp_opcode_decoder
    import vcp_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 16
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CTRL_W-1:0]   ctrl_word
);

    ctrl_word_t w;

    always_comb begin
        w = '0;
        case (opcode)
            OPCODE_W'(OP_NOP), OPCODE_W'(OP_BEQ): begin
                w = '0;
            end
            OPCODE_W'(OP_ADD): begin
                w.wre    = 1'b1;
                w.wb_sel = WB_SEL_ALU;
                w.alu_op = ALU_ADD;
            end
            OPCODE_W'(OP_ADDV): begin
                w.vector_wre = 1'b1;
                w.wb_sel     = WB_SEL_ALU;
                w.alu_op     = ALU_ADD;
            end
            OPCODE_W'(OP_STR): begin
                w.wme = 1'b1;
            end
            OPCODE_W'(OP_LDR): begin
                w.load   = 1'b1;
                w.wre    = 1'b1;
                w.alu_op = ALU_ADD;
            end
            default: begin
`ifdef VCP_ILLEGAL_TRAP_EN
                w.illegal = 1'b1;
`else
                w = '0;
`endif
            end
        endcase
    end

    assign ctrl_word = CTRL_W'(w);

endmodule

// File: rtl/vector_control_pipe.sv
// rtl/vector_control_pipe.sv - opcode sequencer with EX/MEM/WB control-word pipeline
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   op_valid, opCode    opcode offer from upstream; op_ready high in IDLE only
//   stall_in            freezes every stage register, the FSM and beat counter
//   flush               clears EX and abandons any vector op; MEM/WB still advance
//   ctrl_ex/mem/wb      registered control word per stage
//   lane_idx_ex         beat index of the word in EX (0 for scalars/bubbles)
//   busy                vector op in progress
//   illegal             (VCP_ILLEGAL_TRAP_EN only) sticky unknown-opcode flag
// Macro VCP_ILLEGAL_TRAP_EN enables the illegal-opcode trap.
module vector_control_pipe
    import vcp_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 16,
    parameter int VLEN     = 8,
    parameter int LANES    = 2,
    localparam int BEATS   = VLEN / LANES,
    localparam int LIDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [OPCODE_W-1:0] opCode,
    output logic                op_ready,
    input  logic                stall_in,
    input  logic                flush,
    output logic [CTRL_W-1:0]   ctrl_ex,
    output logic [CTRL_W-1:0]   ctrl_mem,
    output logic [CTRL_W-1:0]   ctrl_wb,
    output logic [LIDX_W-1:0]   lane_idx_ex,
    output logic                busy
`ifdef VCP_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    localparam logic [LIDX_W-1:0] LAST_BEAT = LIDX_W'(BEATS - 1);

    vcp_state_t          state_q;
    logic [LIDX_W-1:0]   beat_q;      // next beat index to issue while in VEC_ISSUE
    logic [CTRL_W-1:0]   vec_word_q;  // upstream may drop the opcode after accept
    logic [CTRL_W-1:0]   dec_word;
    logic                accept;
    logic                dec_is_vector;

    vcp_opcode_decoder #(
        .OPCODE_W (OPCODE_W),
        .CTRL_W   (CTRL_W)
    ) u_decoder (
        .opcode    (opCode),
        .ctrl_word (dec_word)
    );

    assign op_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q == ST_VEC_ISSUE);
    assign accept        = op_valid & op_ready & ~stall_in & ~flush;
    assign dec_is_vector = dec_word[BIT_VECTOR_WRE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            vec_word_q  <= '0;
            ctrl_ex     <= '0;
            ctrl_mem    <= '0;
            ctrl_wb     <= '0;
            lane_idx_ex <= '0;
        end else if (flush) begin
            // Flush wins over stall: the older MEM/WB entries still drain.
            ctrl_wb     <= ctrl_mem;
            ctrl_mem    <= ctrl_ex;
            ctrl_ex     <= '0;
            lane_idx_ex <= '0;
            state_q     <= ST_IDLE;
            beat_q      <= '0;
        end else if (!stall_in) begin
            ctrl_wb  <= ctrl_mem;
            ctrl_mem <= ctrl_ex;
            case (state_q)
                ST_IDLE: begin
                    lane_idx_ex <= '0;
                    if (accept) begin
                        ctrl_ex <= dec_word;
                        // A single-beat vector completes in this cycle.
                        if (dec_is_vector && (BEATS > 1)) begin
                            state_q    <= ST_VEC_ISSUE;
                            beat_q     <= LIDX_W'(1);
                            vec_word_q <= dec_word;
                        end
                    end else begin
                        ctrl_ex <= '0;
                    end
                end
                ST_VEC_ISSUE: begin
                    ctrl_ex     <= vec_word_q;
                    lane_idx_ex <= beat_q;
                    if (beat_q == LAST_BEAT) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + LIDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

`ifdef VCP_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= 1'b0;
        end else if (accept && dec_word[BIT_ILLEGAL]) begin
            illegal <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_control_pipe.sv
// tb/tb_vector_control_pipe.sv - scoreboard bench for vector_control_pipe
module tb_vector_control_pipe;

    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 16;
    localparam int VLEN     = 8;
    localparam int LANES    = 2;
    localparam int BEATS    = VLEN / LANES;

    logic                clk = 1'b0;
    logic                rst;
    logic                op_valid;
    logic [OPCODE_W-1:0] opCode;
    logic                op_ready;
    logic                stall_in;
    logic                flush;
    logic [CTRL_W-1:0]   ctrl_ex;
    logic [CTRL_W-1:0]   ctrl_mem;
    logic [CTRL_W-1:0]   ctrl_wb;
    logic [1:0]          lane_idx_ex;
    logic                busy;
`ifdef VCP_ILLEGAL_TRAP_EN
    logic                illegal;
`endif

    always #5 clk = ~clk;

    vector_control_pipe #(
        .OPCODE_W (OPCODE_W),
        .CTRL_W   (CTRL_W),
        .VLEN     (VLEN),
        .LANES    (LANES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .opCode      (opCode),
        .op_ready    (op_ready),
        .stall_in    (stall_in),
        .flush       (flush),
        .ctrl_ex     (ctrl_ex),
        .ctrl_mem    (ctrl_mem),
        .ctrl_wb     (ctrl_wb),
        .lane_idx_ex (lane_idx_ex),
        .busy        (busy)
`ifdef VCP_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    typedef struct {
        logic [15:0] ex;
        logic [15:0] mem;
        logic [15:0] wb;
        logic [1:0]  lane;
        logic        rdy;
        logic        bsy;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        logic [1:0]  lane;
    } beat_t;

    exp_t  exp_q[$];
    beat_t issue_q[$];   // words the sequencer still owes to EX

    logic [15:0] m_ex, m_mem, m_wb;
    logic [1:0]  m_lane;
    logic        m_ill;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [15:0] ref_decode(input logic [3:0] op);
        case (op)
            4'b0000: return 16'h0000;
            4'b0001: return 16'h0091;
            4'b0010: return 16'h0211;
            4'b1010: return 16'h0040;
            4'b1001: return 16'h0181;
            4'b0100: return 16'h0000;
`ifdef VCP_ILLEGAL_TRAP_EN
            default: return 16'h0400;
`else
            default: return 16'h0000;
`endif
        endcase
    endfunction

    function automatic bit is_unknown(input logic [3:0] op);
        return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b1010, 4'b1001, 4'b0100});
    endfunction

    task automatic model_reset();
        issue_q.delete();
        m_ex = '0; m_mem = '0; m_wb = '0; m_lane = '0; m_ill = 1'b0;
    endtask

    // One clock: drive inputs after the falling edge, predict post-edge state.
    task automatic cycle(input logic v, input logic [3:0] op, input logic st, input logic fl);
        exp_t        e;
        beat_t       b;
        logic [15:0] w;
        @(negedge clk);
        op_valid = v; opCode = op; stall_in = st; flush = fl;
        if (fl) begin
            issue_q.delete();
            m_wb = m_mem; m_mem = m_ex; m_ex = '0; m_lane = '0;
        end else if (!st) begin
            if (v && issue_q.size() == 0) begin
                w = ref_decode(op);
                if (op == 4'b0010) begin
                    for (int i = 0; i < BEATS; i++) begin
                        b.word = w; b.lane = 2'(i);
                        issue_q.push_back(b);
                    end
                end else begin
                    b.word = w; b.lane = 2'd0;
                    issue_q.push_back(b);
                end
`ifdef VCP_ILLEGAL_TRAP_EN
                if (is_unknown(op)) m_ill = 1'b1;
`endif
            end
            m_wb = m_mem; m_mem = m_ex;
            if (issue_q.size() > 0) begin
                b = issue_q.pop_front();
                m_ex = b.word; m_lane = b.lane;
            end else begin
                m_ex = '0; m_lane = '0;
            end
        end
        e.ex = m_ex; e.mem = m_mem; e.wb = m_wb; e.lane = m_lane;
        e.rdy = (issue_q.size() == 0);
        e.bsy = (issue_q.size() != 0);
        e.ill = m_ill;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge the DUT presents a new set of stage words.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctrl_ex",     32'(ctrl_ex),     32'(e.ex));
            chk("ctrl_mem",    32'(ctrl_mem),    32'(e.mem));
            chk("ctrl_wb",     32'(ctrl_wb),     32'(e.wb));
            chk("lane_idx_ex", 32'(lane_idx_ex), 32'(e.lane));
            chk("op_ready",    32'(op_ready),    32'(e.rdy));
            chk("busy",        32'(busy),        32'(e.bsy));
`ifdef VCP_ILLEGAL_TRAP_EN
            chk("illegal",     32'(illegal),     32'(e.ill));
`endif
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl_ex"},  32'(ctrl_ex),     32'h0);
        chk({tag, "_ctrl_mem"}, 32'(ctrl_mem),    32'h0);
        chk({tag, "_ctrl_wb"},  32'(ctrl_wb),     32'h0);
        chk({tag, "_lane"},     32'(lane_idx_ex), 32'h0);
        chk({tag, "_busy"},     32'(busy),        32'h0);
        chk({tag, "_op_ready"}, 32'(op_ready),    32'h1);
`ifdef VCP_ILLEGAL_TRAP_EN
        chk({tag, "_illegal"},  32'(illegal),     32'h0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    logic [3:0] op_tab [6];

    initial begin
        op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1010, 4'b0100};
        rst = 1'b0; op_valid = 1'b0; opCode = '0; stall_in = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Scalar add through all three stages.
        cycle(1'b1, 4'b0001, 1'b0, 1'b0);
        idle(3);
        // Full vector; a held opcode offered while busy must be ignored.
        cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0, 1'b0);
        idle(4);
        // Vector with a two-cycle stall after beat 1.
        cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 4'b0000, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(5);
        // Vector flushed while beat 2 sits in EX.
        cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        idle(4);
        // Flush with stall, and flush suppressing an offered opcode.
        cycle(1'b1, 4'b0001, 1'b0, 1'b0);
        cycle(1'b1, 4'b1001, 1'b1, 1'b1);
        idle(3);
        // ldr/str back-to-back, then an unknown opcode.
        cycle(1'b1, 4'b1001, 1'b0, 1'b0);
        cycle(1'b1, 4'b1010, 1'b0, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0, 1'b0);
        idle(4);

        // Reset in the middle of a vector.
        cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        op_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_vec_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic       v, st, fl;
            logic [3:0] op;
            v  = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 99) < 15);
            fl = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
            else                           op = op_tab[$urandom_range(0, 5)];
            cycle(v, op, st, fl);
        end
        idle(3);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_control_pipe.md
VECTOR_CONTROL_PIPE -- requirements
Module: vector_control_pipe

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode width.
REQ-002 Parameter CTRL_W, default 16, control-word width (>=11).
REQ-003 Parameter VLEN, default 8, vector elements per vector instruction.
REQ-004 Parameter LANES, default 2, elements processed per beat; VLEN SHALL be a multiple of LANES; BEATS = VLEN/LANES.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 op_valid  in  1  opCode valid this cycle.
REQ-008 opCode  in  OPCODE_W  instruction opcode.
REQ-009 op_ready  out  1  sequencer can accept an opcode.
REQ-010 stall_in  in  1  downstream hold; freezes the whole pipe.
REQ-011 flush  in  1  kill EX-stage entry and any vector op in progress.
REQ-012 ctrl_ex / ctrl_mem / ctrl_wb  out  CTRL_W each  registered control word per stage.
REQ-013 lane_idx_ex  out  max(1,$clog2(BEATS))  beat index of the word in EX.
REQ-014 busy  out  1  vector op in progress.

Function
REQ-015 Control word SHALL be {pad, vector_wre[9], load[8], wre[7], wme[6], wb_sel[5:4], aluOp[3:0]}, pad zero.
REQ-016 Decode: 0000 nop all 0; 0001 add wre=1,wb_sel=01,aluOp=0001; 0010 add.V vector_wre=1,wb_sel=01,aluOp=0001; 1010 str wme=1; 1001 ldr load=1,wre=1,aluOp=0001; 0100 beq all 0; others all 0.
REQ-017 Accept = op_valid & op_ready & !stall_in; non-accepted cycles in IDLE insert a zero word (bubble) into EX.
REQ-018 Latency: opcode accepted in cycle N appears on ctrl_ex at N+1, ctrl_mem N+2, ctrl_wb N+3.
REQ-019 When !stall_in: ctrl_wb<=ctrl_mem, ctrl_mem<=ctrl_ex, ctrl_ex<=new word or bubble; when stall_in: all stage registers, FSM and beat counter hold.
REQ-020 FSM states IDLE, VEC_ISSUE; op_ready=1 only in IDLE; busy=1 only in VEC_ISSUE.
REQ-021 IDLE, accept of 0010 with BEATS>1: issue beat 0 (lane_idx 0), go VEC_ISSUE; with BEATS==1 stay IDLE.
REQ-022 VEC_ISSUE: each non-stalled cycle issue the same vector word with lane_idx+1; after issuing beat BEATS-1 return to IDLE.
REQ-023 Scalar words and bubbles SHALL carry lane_idx_ex=0.
REQ-024 flush (takes priority over stall_in): ctrl_ex<=0, lane_idx_ex<=0, FSM<=IDLE, counter<=0, no accept that cycle; ctrl_mem/ctrl_wb advance normally.
REQ-025 op_valid while op_ready=0 SHALL be ignored (upstream holds opcode).

Reset
REQ-026 On rst low: ctrl_ex/mem/wb=0, lane_idx_ex=0, FSM=IDLE, counter=0, busy=0, op_ready=1, illegal=0 if present.
REQ-027 Reset mid-vector SHALL abandon remaining beats; first post-reset cycle is IDLE.

Configuration
REQ-028 Macro VCP_ILLEGAL_TRAP_EN defined: unknown opcode sets control bit 10, adds output illegal (1 bit, sticky until reset) set the cycle after accept.
REQ-029 Macro undefined: bit 10 stays 0, no illegal port, unknown opcodes decode as nop.

Structure
REQ-030 Package vcp_pkg SHALL hold opcode constants, control-word bit positions, ctrl_word_t, state enum.
REQ-031 Combinational sub-module vcp_opcode_decoder SHALL implement REQ-016 (and REQ-028 bit); sequencer and stage registers stay in top.

Verification (VLEN=8, LANES=2, BEATS=4)
REQ-032 Reset then add (0001) accepted cycle 0 -> ctrl_ex=0x0091 cycle 1, ctrl_mem=0x0091 cycle 2, ctrl_wb=0x0091 cycle 3.
REQ-033 add.V (0010) accepted -> ctrl_ex=0x0211 four consecutive cycles with lane_idx 0,1,2,3; op_ready=0 for three cycles; busy low after beat 3.
REQ-034 add.V, stall_in high 2 cycles after beat 1 -> all stages, lane_idx=1 hold 2 cycles; beats 2,3 follow, total 6 cycles.
REQ-035 add.V, flush during beat 2 -> ctrl_ex=0 next cycle, FSM IDLE, op_ready=1, beat 3 never issued; ctrl_mem gets beat 2.
REQ-036 ldr (1001) then str (1010) back-to-back -> ctrl_ex 0x0181 then 0x0040; rst low mid add.V -> all outputs 0 immediately.
REQ-037 Opcode 1111 with VCP_ILLEGAL_TRAP_EN -> ctrl_ex=0x0400, illegal=1 and stays 1; without macro -> ctrl_ex=0x0000.
